jogador_automatico: RTL and testbench
=====================================

// Module: jogador_automatico
// PURPOSE
// - Autonomous player for jogo_desafio_memoria: watches the game's leds[3:0] while a sequence is shown, stores it, then replays it on botoes[3:0].
// - Sits beside the game in the top-level and in benches. It is the responding end of the leds->botoes interface and runs full games without hand-written stimulus.
// PARAMETERS
// - MAX_JOGADAS     16   capacity of the sequence buffer (entries)
// - SILENCIO_CICLOS 300  consecutive leds==0 cycles that end a display phase
// - PRESS_CICLOS    50   cycles each botoes press is held
// - GAP_CICLOS      50   cycles of botoes==0 between presses
// PORTS
// - clock        in   1   system clock (1 ms period in benches)
// - reset        in   1   synchronous, active-low; sampled on rising edge of clock
// - habilitar    in   1   start/keep playing; low returns to OCIOSO
// - errar        in   1   inject a wrong press on the last entry of a replay
// - leds         in   4   game display, one-hot or 0
// - ganhou       in   1   game won (level)
// - perdeu       in   1   game lost (level)
// - timeout      in   1   game timeout (level)
// - jogar        out  1   start pulse to the game
// - botoes       out  4   one-hot press or 0
// - ocupado      out  1   high in every state except OCIOSO and FIM
// - n_capturadas out  5   entries stored in the current round
// - erro_captura out  1   sticky: non-one-hot leds pattern or buffer overflow
// BEHAVIOUR
// - Reset (reset==0 at an edge): state OCIOSO; jogar=0, botoes=0, ocupado=0, n_capturadas=0, erro_captura=0, leds_ant=0. Applies in any state, including mid-press.
// - All outputs are registered. Inputs are sampled once per edge and are not synchronised here.
// - OCIOSO: on habilitar==1 -> INICIA; clear the buffer and erro_captura.
// - INICIA: jogar=1 for exactly 2 cycles -> CAPTURA.
// - CAPTURA:
//   - Capture event = leds!=0 && leds_ant==0 (rising from blank). Write leds at wr_ptr, wr_ptr++, n_capturadas++. The event becomes visible 1 cycle after the sampled edge.
//   - Non-one-hot leds at a capture event: set erro_captura and go -> FIM.
//   - Capture event with n_capturadas==MAX_JOGADAS: set erro_captura and go -> FIM. Nothing is written.
//   - sil_cnt counts consecutive leds==0 cycles. It resets on any leds!=0.
//   - When sil_cnt==SILENCIO_CICLOS-1 and n_capturadas>=1: go -> PRESS with rd_ptr=0.
//   - With n_capturadas==0 the block waits indefinitely.
// - PRESS: botoes=buf[rd_ptr] for PRESS_CICLOS cycles, then -> GAP.
//   - errar==1 when entering PRESS with rd_ptr==n_capturadas-1: drive {buf[2:0],buf[3]} (rotate left) instead.
// - GAP: botoes=0 for GAP_CICLOS cycles.
//   - If rd_ptr==n_capturadas-1: clear the buffer (n_capturadas=0, wr_ptr=0), clear sil_cnt, go -> CAPTURA.
//   - Otherwise rd_ptr++ and go -> PRESS.
// - ganhou|perdeu|timeout==1 in INICIA/CAPTURA/PRESS/GAP: go -> FIM on the next edge. botoes=0 immediately from that edge; an ongoing press is truncated. This has priority over every other transition.
// - FIM: botoes=0, jogar=0. Stays in FIM while habilitar==1; habilitar==0 -> OCIOSO.
// - habilitar==0 in any other state: go -> OCIOSO and botoes=0. erro_captura is kept.
// - Simultaneous events:
//   - reset beats everything.
//   - End-of-game beats habilitar==0.
//   - habilitar==0 beats a capture event or a timer expiry.
//   - A capture event and silence expiry cannot coincide.
// - Widths:
//   - Pointers are $clog2(MAX_JOGADAS) bits.
//   - n_capturadas saturates at MAX_JOGADAS and is zero-extended to 5 bits.
//   - Cycle counters are sized for the largest of PRESS_CICLOS, GAP_CICLOS and SILENCIO_CICLOS; no wrap inside a phase.
// STRUCTURE
// - Package jogador_pkg: state encodings (OCIOSO, INICIA, CAPTURA, PRESS, GAP, FIM as 3-bit localparams) and the helper function eh_one_hot(4b).
// - Sub-module fila_jogadas (MAX_JOGADAS x 4b register file; write port with wr_ptr, combinational read at rd_ptr, synchronous clear).
// - Top: FSM, timers and edge detector.
// TESTING
// - Reset held 40 cycles mid-PRESS -> next edge botoes=0, ocupado=0, n_capturadas=0, state OCIOSO.
// - Behavioural game model shows 0001, then 0001,0100 (each 100 on / 100 off).
//   - Required: jogar high 2 cycles; n_capturadas=1, then 2.
//   - Required replay: 0001 held 50 cycles, then 0001,0100 with 50-cycle gaps.
// - Real jogo_desafio_memoria, configuracao=01, habilitar=1, errar=0 -> ganhou=1; block reaches FIM with erro_captura=0.
// - Same setup with errar=1 in round 2, sequence 0010 -> last press is 0100; game asserts perdeu; block reaches FIM within 1 cycle, botoes=0.
// - leds=0011 at a capture event -> erro_captura=1, FIM. Also: 17 captures with MAX_JOGADAS=16 -> erro_captura=1, n_capturadas=16.
// - timeout asserted during GAP and during CAPTURA -> FIM next edge. habilitar=0 in FIM -> OCIOSO, ocupado=0.

Source files
------------

// File: rtl/jogador_pkg.sv
// Shared types for the autonomous memory-game player.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package jogador_pkg;

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        INICIA  = 3'd1,
        CAPTURA = 3'd2,
        PRESS   = 3'd3,
        GAP     = 3'd4,
        FIM     = 3'd5
    } estado_t;

    function automatic logic eh_one_hot(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/jogador_automatico_if.sv
// leds->botoes link between jogo_desafio_memoria (master) and the player (slave).
// Latency: wires only.
// Backpressure: none; the game paces the exchange through display timing.
interface jogador_automatico_if;
    logic [3:0] leds;
    logic       ganhou;
    logic       perdeu;
    logic       timeout;
    logic       jogar;
    logic [3:0] botoes;

    modport master (output leds, ganhou, perdeu, timeout, input jogar, botoes);
    modport slave  (input leds, ganhou, perdeu, timeout, output jogar, botoes);
endinterface

// File: rtl/fila_jogadas.sv
// Sequence buffer: MAX_JOGADAS x 4b register file, one write port, one combinational read.
// Latency: write visible on the read port the cycle after the write edge.
// Backpressure: none; the caller guards against overflow.
module fila_jogadas #(
    parameter int MAX_JOGADAS = 16,
    parameter int PTR_W       = $clog2(MAX_JOGADAS)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             we,
    input  logic [PTR_W-1:0] wr_ptr,
    input  logic [3:0]       wr_dat,
    input  logic [PTR_W-1:0] rd_ptr,
    output logic [3:0]       rd_dat
);

    logic [3:0] mem [MAX_JOGADAS];

    always_ff @(posedge clock) begin
        if (!reset || clr) begin
            for (int i = 0; i < MAX_JOGADAS; i++) begin
                mem[i] <= 4'd0;
            end
        end else if (we) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    assign rd_dat = mem[rd_ptr];

endmodule

// File: rtl/jogador_automatico.sv
// Autonomous player: captures the game's led sequence, then replays it on botoes.
// Latency: all outputs registered; a press starts the edge after SILENCIO_CICLOS blank samples.
// Backpressure: none; end-of-game or habilitar low aborts any phase on the next edge.
module jogador_automatico
    import jogador_pkg::*;
#(
    parameter int MAX_JOGADAS     = 16,
    parameter int SILENCIO_CICLOS = 300,
    parameter int PRESS_CICLOS    = 50,
    parameter int GAP_CICLOS      = 50
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  habilitar,
    input  logic                  errar,
    jogador_automatico_if.slave   jogo,
    output logic                  ocupado,
    output logic [4:0]            n_capturadas,
    output logic                  erro_captura
);

    localparam int PTR_W = $clog2(MAX_JOGADAS);
    localparam int CNT_W = $clog2(max3(PRESS_CICLOS, GAP_CICLOS, SILENCIO_CICLOS));

    localparam logic [CNT_W-1:0] SIL_FIM   = CNT_W'(SILENCIO_CICLOS - 1);
    localparam logic [CNT_W-1:0] PRESS_FIM = CNT_W'(PRESS_CICLOS - 1);
    localparam logic [CNT_W-1:0] GAP_FIM   = CNT_W'(GAP_CICLOS - 1);
    localparam logic [4:0]       N_MAX     = 5'(MAX_JOGADAS);

    estado_t          estado, estado_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [PTR_W-1:0] wr_ptr, wr_ptr_nxt;
    logic [PTR_W-1:0] rd_ptr, rd_ptr_nxt;
    logic [4:0]       n_cnt, n_nxt;
    logic             erro_q, erro_nxt;
    logic [3:0]       leds_ant;
    logic             jogar_q;
    logic [3:0]       botoes_q, botoes_nxt;
    logic             ocupado_q;

    logic             fila_we, fila_clr;
    logic [3:0]       fila_rd_dat;
    logic             fim_jogo, captura_evt;
    logic             ultima;
    logic [3:0]       press_val;

    fila_jogadas #(
        .MAX_JOGADAS (MAX_JOGADAS),
        .PTR_W       (PTR_W)
    ) u_fila (
        .clock  (clock),
        .reset  (reset),
        .clr    (fila_clr),
        .we     (fila_we),
        .wr_ptr (wr_ptr),
        .wr_dat (jogo.leds),
        .rd_ptr (rd_ptr_nxt),
        .rd_dat (fila_rd_dat)
    );

    assign fim_jogo    = jogo.ganhou | jogo.perdeu | jogo.timeout;
    assign captura_evt = (jogo.leds != 4'd0) && (leds_ant == 4'd0);

    always_comb begin
        estado_nxt = estado;
        cnt_nxt    = cnt;
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        n_nxt      = n_cnt;
        erro_nxt   = erro_q;
        fila_we    = 1'b0;
        fila_clr   = 1'b0;
        case (estado)
            OCIOSO: begin
                if (habilitar) begin
                    estado_nxt = INICIA;
                    cnt_nxt    = '0;
                    wr_ptr_nxt = '0;
                    n_nxt      = '0;
                    erro_nxt   = 1'b0;
                    fila_clr   = 1'b1;
                end
            end
            INICIA: begin
                if (fim_jogo)              estado_nxt = FIM;
                else if (!habilitar)       estado_nxt = OCIOSO;
                else if (cnt == CNT_W'(1)) begin
                    estado_nxt = CAPTURA;
                    cnt_nxt    = '0;
                end else                   cnt_nxt = cnt + CNT_W'(1);
            end
            CAPTURA: begin
                if (fim_jogo)             estado_nxt = FIM;
                else if (!habilitar)      estado_nxt = OCIOSO;
                else if (captura_evt) begin
                    cnt_nxt = '0;
                    if (!eh_one_hot(jogo.leds) || n_cnt == N_MAX) begin
                        erro_nxt   = 1'b1;
                        estado_nxt = FIM;
                    end else begin
                        fila_we    = 1'b1;
                        wr_ptr_nxt = wr_ptr + PTR_W'(1);
                        n_nxt      = n_cnt + 5'd1;
                    end
                end else if (jogo.leds != 4'd0) begin
                    cnt_nxt = '0;
                end else if (cnt == SIL_FIM) begin
                    // Saturate silently until something has been captured.
                    if (n_cnt != 5'd0) begin
                        estado_nxt = PRESS;
                        rd_ptr_nxt = '0;
                        cnt_nxt    = '0;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            PRESS: begin
                if (fim_jogo)              estado_nxt = FIM;
                else if (!habilitar)       estado_nxt = OCIOSO;
                else if (cnt == PRESS_FIM) begin
                    estado_nxt = GAP;
                    cnt_nxt    = '0;
                end else                   cnt_nxt = cnt + CNT_W'(1);
            end
            GAP: begin
                if (fim_jogo)            estado_nxt = FIM;
                else if (!habilitar)     estado_nxt = OCIOSO;
                else if (cnt == GAP_FIM) begin
                    cnt_nxt = '0;
                    if ((5'(rd_ptr) + 5'd1) == n_cnt) begin
                        estado_nxt = CAPTURA;
                        wr_ptr_nxt = '0;
                        n_nxt      = '0;
                        fila_clr   = 1'b1;
                    end else begin
                        estado_nxt = PRESS;
                        rd_ptr_nxt = rd_ptr + PTR_W'(1);
                    end
                end else                 cnt_nxt = cnt + CNT_W'(1);
            end
            FIM: begin
                if (!habilitar) estado_nxt = OCIOSO;
            end
            default: estado_nxt = OCIOSO;
        endcase
    end

    // The press value is latched once, on entry to PRESS, so errar only matters then.
    always_comb begin
        press_val  = fila_rd_dat;
        ultima     = (5'(rd_ptr_nxt) + 5'd1) == n_cnt;
        botoes_nxt = 4'd0;
        if (estado_nxt == PRESS) begin
            if (estado != PRESS)
                botoes_nxt = (errar && ultima) ? {press_val[2:0], press_val[3]} : press_val;
            else
                botoes_nxt = botoes_q;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            estado    <= OCIOSO;
            cnt       <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            n_cnt     <= '0;
            erro_q    <= 1'b0;
            leds_ant  <= 4'd0;
            jogar_q   <= 1'b0;
            botoes_q  <= 4'd0;
            ocupado_q <= 1'b0;
        end else begin
            estado    <= estado_nxt;
            cnt       <= cnt_nxt;
            wr_ptr    <= wr_ptr_nxt;
            rd_ptr    <= rd_ptr_nxt;
            n_cnt     <= n_nxt;
            erro_q    <= erro_nxt;
            leds_ant  <= jogo.leds;
            jogar_q   <= (estado_nxt == INICIA);
            botoes_q  <= botoes_nxt;
            ocupado_q <= (estado_nxt != OCIOSO) && (estado_nxt != FIM);
        end
    end

    assign jogo.jogar   = jogar_q;
    assign jogo.botoes  = botoes_q;
    assign ocupado      = ocupado_q;
    assign n_capturadas = n_cnt;
    assign erro_captura = erro_q;

endmodule

// File: tb/tb_jogador_automatico.sv
// Bench for jogador_automatico: a behavioural game shows sequences and checks the replay.
module tb_jogador_automatico;

    localparam int MAXJ = 16;
    localparam int SIL  = 300;
    localparam int PRS  = 50;
    localparam int GAPC = 50;

    logic       clock = 1'b0;
    logic       reset;
    logic       habilitar;
    logic       errar;
    logic       ocupado;
    logic [4:0] n_capturadas;
    logic       erro_captura;

    jogador_automatico_if jogo_bus ();

    jogador_automatico #(
        .MAX_JOGADAS     (MAXJ),
        .SILENCIO_CICLOS (SIL),
        .PRESS_CICLOS    (PRS),
        .GAP_CICLOS      (GAPC)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .habilitar    (habilitar),
        .errar        (errar),
        .jogo         (jogo_bus),
        .ocupado      (ocupado),
        .n_capturadas (n_capturadas),
        .erro_captura (erro_captura)
    );

    always #5 clock = ~clock;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [3:0] seq     [32];
    logic [3:0] obs_val [32];
    int         obs_len [32];
    int         obs_gap [32];
    int         obs_lat;
    bit         obs_ok;

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    function automatic logic [3:0] rand_onehot();
        logic [3:0] u;
        u = 4'b0001;
        return u << $urandom_range(3, 0);
    endfunction

    // Game display: each entry lit for a random time, blank between; ends on the last blank edge.
    task automatic show(input int len, input int on_lo, input int on_hi, input int off_lo, input int off_hi);
        for (int i = 0; i < len; i++) begin
            jogo_bus.leds = seq[i];
            cyc(int'($urandom_range(on_hi, on_lo)));
            jogo_bus.leds = 4'd0;
            if (i < len - 1) cyc(int'($urandom_range(off_hi, off_lo)));
        end
    endtask

    task automatic start_game(output int hi);
        hi = 0;
        habilitar = 1'b1;
        for (int k = 0; k < 10; k++) begin
            cyc(1);
            if (jogo_bus.jogar) hi++;
            else if (hi > 0) break;
        end
    endtask

    // Records latency to first press, each press value/length and the gaps between presses.
    task automatic watch(input int n, input bit stop_last);
        obs_ok  = 1'b1;
        obs_lat = 0;
        do begin
            cyc(1);
            obs_lat++;
        end while (jogo_bus.botoes == 4'd0 && obs_lat < 2000);
        if (jogo_bus.botoes == 4'd0) begin
            obs_ok = 1'b0;
            return;
        end
        for (int i = 0; i < n; i++) begin
            obs_val[i] = jogo_bus.botoes;
            obs_len[i] = 0;
            obs_gap[i] = 0;
            if (stop_last && i == n - 1) return;
            while (jogo_bus.botoes == obs_val[i] && obs_len[i] < 500) begin
                obs_len[i]++;
                cyc(1);
            end
            if (i < n - 1) begin
                while (jogo_bus.botoes == 4'd0 && obs_gap[i] < 500) begin
                    obs_gap[i]++;
                    cyc(1);
                end
                if (jogo_bus.botoes == 4'd0) begin
                    obs_ok = 1'b0;
                    return;
                end
            end
        end
    endtask

    task automatic test_reset();
        int hi;
        n_cmp++; if (jogo_bus.botoes !== 4'd0) begin n_err++; $display("FAIL rst_botoes: got %b want 0000", jogo_bus.botoes); end
        n_cmp++; if (jogo_bus.jogar !== 1'b0) begin n_err++; $display("FAIL rst_jogar: got %b want 0", jogo_bus.jogar); end
        n_cmp++; if (ocupado !== 1'b0) begin n_err++; $display("FAIL rst_ocupado: got %b want 0", ocupado); end
        n_cmp++; if (n_capturadas !== 5'd0) begin n_err++; $display("FAIL rst_n: got %0d want 0", n_capturadas); end
        n_cmp++; if (erro_captura !== 1'b0) begin n_err++; $display("FAIL rst_erro: got %b want 0", erro_captura); end
        reset = 1'b1;
        cyc(2);
        start_game(hi);
        seq[0] = rand_onehot();
        show(1, 30, 60, 10, 10);
        watch(1, 1'b1);
        n_cmp++; if (obs_ok !== 1'b1) begin n_err++; $display("FAIL rst_press_seen: got %b want 1", obs_ok); end
        cyc(10);
        reset = 1'b0;
        cyc(1);
        n_cmp++; if (jogo_bus.botoes !== 4'd0) begin n_err++; $display("FAIL rstmid_botoes: got %b want 0000", jogo_bus.botoes); end
        n_cmp++; if (ocupado !== 1'b0) begin n_err++; $display("FAIL rstmid_ocupado: got %b want 0", ocupado); end
        n_cmp++; if (n_capturadas !== 5'd0) begin n_err++; $display("FAIL rstmid_n: got %0d want 0", n_capturadas); end
        cyc(39);
        n_cmp++; if (jogo_bus.botoes !== 4'd0 || ocupado !== 1'b0) begin n_err++; $display("FAIL rsthold: got botoes=%b ocupado=%b want 0000/0", jogo_bus.botoes, ocupado); end
        reset = 1'b1;
        start_game(hi);
        n_cmp++; if (hi !== 2) begin n_err++; $display("FAIL rst_to_ocioso_jogar: got %0d want 2", hi); end
        habilitar = 1'b0;
        cyc(2);
    endtask

    task automatic test_partida(input bit aleat, input int nrod);
        int hi, on_lo, on_hi, off_lo, off_hi;
        if (aleat) begin
            for (int i = 0; i < nrod; i++) seq[i] = rand_onehot();
            on_lo = 5; on_hi = 100; off_lo = 5; off_hi = 150;
        end else begin
            seq[0] = 4'b0001; seq[1] = 4'b0100;
            on_lo = 100; on_hi = 100; off_lo = 100; off_hi = 100;
        end
        start_game(hi);
        n_cmp++; if (hi !== 2) begin n_err++; $display("FAIL jogar_ciclos: got %0d want 2", hi); end
        for (int r = 1; r <= nrod; r++) begin
            show(r, on_lo, on_hi, off_lo, off_hi);
            n_cmp++; if (n_capturadas !== 5'(r)) begin n_err++; $display("FAIL n_capturadas r%0d: got %0d want %0d", r, n_capturadas, r); end
            watch(r, 1'b0);
            n_cmp++; if (obs_ok !== 1'b1) begin n_err++; $display("FAIL replay_timeout r%0d: got %b want 1", r, obs_ok); end
            n_cmp++; if (obs_lat !== SIL) begin n_err++; $display("FAIL silencio r%0d: got %0d want %0d", r, obs_lat, SIL); end
            for (int i = 0; i < r; i++) begin
                n_cmp++; if (obs_val[i] !== seq[i]) begin n_err++; $display("FAIL press_val r%0d i%0d: got %b want %b", r, i, obs_val[i], seq[i]); end
                n_cmp++; if (obs_len[i] !== PRS) begin n_err++; $display("FAIL press_len r%0d i%0d: got %0d want %0d", r, i, obs_len[i], PRS); end
                if (i < r - 1) begin
                    n_cmp++; if (obs_gap[i] !== GAPC) begin n_err++; $display("FAIL gap_len r%0d i%0d: got %0d want %0d", r, i, obs_gap[i], GAPC); end
                end
            end
            if (r < nrod) cyc(60);
        end
        jogo_bus.ganhou = 1'b1;
        cyc(1);
        n_cmp++; if (ocupado !== 1'b0 || jogo_bus.botoes !== 4'd0) begin n_err++; $display("FAIL ganhou_fim: got ocupado=%b botoes=%b want 0/0000", ocupado, jogo_bus.botoes); end
        n_cmp++; if (erro_captura !== 1'b0) begin n_err++; $display("FAIL ganhou_erro: got %b want 0", erro_captura); end
        cyc(5);
        n_cmp++; if (jogo_bus.jogar !== 1'b0 || ocupado !== 1'b0) begin n_err++; $display("FAIL fim_hold: got jogar=%b ocupado=%b want 0/0", jogo_bus.jogar, ocupado); end
        jogo_bus.ganhou = 1'b0;
        habilitar = 1'b0;
        cyc(2);
    endtask

    task automatic test_errar();
        int hi;
        start_game(hi);
        seq[0] = rand_onehot();
        show(1, 20, 80, 20, 80);
        watch(1, 1'b0);
        cyc(60);
        errar  = 1'b1;
        seq[1] = 4'b0010;
        show(2, 20, 80, 20, 80);
        n_cmp++; if (n_capturadas !== 5'd2) begin n_err++; $display("FAIL errar_n: got %0d want 2", n_capturadas); end
        watch(2, 1'b1);
        n_cmp++; if (obs_ok !== 1'b1) begin n_err++; $display("FAIL errar_timeout: got %b want 1", obs_ok); end
        n_cmp++; if (obs_val[0] !== seq[0]) begin n_err++; $display("FAIL errar_first: got %b want %b", obs_val[0], seq[0]); end
        n_cmp++; if (obs_val[1] !== 4'b0100) begin n_err++; $display("FAIL errar_last: got %b want 0100", obs_val[1]); end
        jogo_bus.perdeu = (obs_val[1] != seq[1]);
        cyc(1);
        n_cmp++; if (jogo_bus.botoes !== 4'd0 || ocupado !== 1'b0) begin n_err++; $display("FAIL perdeu_fim: got botoes=%b ocupado=%b want 0000/0", jogo_bus.botoes, ocupado); end
        jogo_bus.perdeu = 1'b0;
        errar = 1'b0;
        habilitar = 1'b0;
        cyc(2);
    endtask

    task automatic test_erro_captura();
        int hi;
        start_game(hi);
        jogo_bus.leds = 4'b0011;
        cyc(5);
        jogo_bus.leds = 4'd0;
        n_cmp++; if (erro_captura !== 1'b1) begin n_err++; $display("FAIL onehot_erro: got %b want 1", erro_captura); end
        n_cmp++; if (ocupado !== 1'b0) begin n_err++; $display("FAIL onehot_fim: got %b want 0", ocupado); end
        cyc(5);
        n_cmp++; if (jogo_bus.jogar !== 1'b0) begin n_err++; $display("FAIL onehot_stay: got jogar=%b want 0", jogo_bus.jogar); end
        habilitar = 1'b0;
        cyc(2);
        n_cmp++; if (erro_captura !== 1'b1) begin n_err++; $display("FAIL erro_kept: got %b want 1", erro_captura); end
        start_game(hi);
        n_cmp++; if (hi !== 2) begin n_err++; $display("FAIL restart_jogar: got %0d want 2", hi); end
        n_cmp++; if (erro_captura !== 1'b0) begin n_err++; $display("FAIL erro_cleared: got %b want 0", erro_captura); end
        for (int i = 0; i < MAXJ + 1; i++) seq[i] = rand_onehot();
        show(MAXJ + 1, 3, 3, 3, 3);
        cyc(2);
        n_cmp++; if (n_capturadas !== 5'(MAXJ)) begin n_err++; $display("FAIL overflow_n: got %0d want %0d", n_capturadas, MAXJ); end
        n_cmp++; if (erro_captura !== 1'b1) begin n_err++; $display("FAIL overflow_erro: got %b want 1", erro_captura); end
        n_cmp++; if (ocupado !== 1'b0) begin n_err++; $display("FAIL overflow_fim: got %b want 0", ocupado); end
        habilitar = 1'b0;
        cyc(2);
    endtask

    task automatic test_timeout();
        int hi;
        start_game(hi);
        seq[0] = rand_onehot();
        show(1, 20, 40, 10, 10);
        watch(1, 1'b0);
        n_cmp++; if (obs_ok !== 1'b1) begin n_err++; $display("FAIL to_press_seen: got %b want 1", obs_ok); end
        cyc(10);
        jogo_bus.timeout = 1'b1;
        cyc(1);
        n_cmp++; if (ocupado !== 1'b0 || jogo_bus.botoes !== 4'd0) begin n_err++; $display("FAIL to_gap: got ocupado=%b botoes=%b want 0/0000", ocupado, jogo_bus.botoes); end
        jogo_bus.timeout = 1'b0;
        cyc(60);
        n_cmp++; if (ocupado !== 1'b0) begin n_err++; $display("FAIL to_gap_hold: got %b want 0", ocupado); end
        habilitar = 1'b0;
        cyc(2);
        start_game(hi);
        n_cmp++; if (hi !== 2) begin n_err++; $display("FAIL fim_to_ocioso: got jogar %0d want 2", hi); end
        show(1, 20, 40, 10, 10);
        cyc(20);
        jogo_bus.timeout = 1'b1;
        cyc(1);
        n_cmp++; if (ocupado !== 1'b0) begin n_err++; $display("FAIL to_captura: got %b want 0", ocupado); end
        jogo_bus.timeout = 1'b0;
        cyc(SIL + 50);
        n_cmp++; if (jogo_bus.botoes !== 4'd0 || ocupado !== 1'b0) begin n_err++; $display("FAIL to_captura_hold: got botoes=%b ocupado=%b want 0000/0", jogo_bus.botoes, ocupado); end
        habilitar = 1'b0;
        cyc(1);
        n_cmp++; if (ocupado !== 1'b0) begin n_err++; $display("FAIL fim_ocioso_ocupado: got %b want 0", ocupado); end
        cyc(2);
    endtask

    task automatic test_desabilitar();
        int hi;
        start_game(hi);
        seq[0] = rand_onehot();
        show(1, 20, 40, 10, 10);
        watch(1, 1'b1);
        cyc(5);
        habilitar = 1'b0;
        cyc(1);
        n_cmp++; if (jogo_bus.botoes !== 4'd0 || ocupado !== 1'b0) begin n_err++; $display("FAIL hab0_press: got botoes=%b ocupado=%b want 0000/0", jogo_bus.botoes, ocupado); end
        cyc(2);
    endtask

    initial begin
        reset            = 1'b0;
        habilitar        = 1'b0;
        errar            = 1'b0;
        jogo_bus.leds    = 4'd0;
        jogo_bus.ganhou  = 1'b0;
        jogo_bus.perdeu  = 1'b0;
        jogo_bus.timeout = 1'b0;
        cyc(3);
        test_reset();
        test_partida(1'b0, 2);
        test_partida(1'b1, 4);
        test_errar();
        test_erro_captura();
        test_timeout();
        test_desabilitar();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #5000000;
        n_err++;
        $display("FAIL watchdog: got no completion want finish before time limit");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog");
    end

endmodule
